// File: rtl/legv8_pkg.sv
// LEGv8 opcode field constants, instruction-class encoding and the
// masked-compare class decoder shared by the fetch/decode pipeline.
package legv8_pkg;

    localparam int OPCODE_W   = 11;
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 21;

    // Full-width opcodes; branch patterns carry zeros in their don't-care bits
    localparam logic [OPCODE_W-1:0] OP_ADDS  = 11'b10101011000;
    localparam logic [OPCODE_W-1:0] OP_SUBS  = 11'b11101011000;
    localparam logic [OPCODE_W-1:0] OP_AND   = 11'b10001010000;
    localparam logic [OPCODE_W-1:0] OP_EOR   = 11'b11001010000;
    localparam logic [OPCODE_W-1:0] OP_LDUR  = 11'b11111000010;
    localparam logic [OPCODE_W-1:0] OP_STUR  = 11'b11111000000;
    localparam logic [OPCODE_W-1:0] OP_B     = 11'b00010100000;
    localparam logic [OPCODE_W-1:0] OP_CBZ   = 11'b10110100000;
    localparam logic [OPCODE_W-1:0] OP_BCOND = 11'b01010100000;

    localparam logic [OPCODE_W-1:0] MASK_FULL = 11'b11111111111;
    localparam logic [OPCODE_W-1:0] MASK_B    = 11'b11111100000;
    localparam logic [OPCODE_W-1:0] MASK_CB   = 11'b11111111000;

    localparam int CLASS_W     = 5;
    localparam int CLS_RTYPE   = 0;
    localparam int CLS_DTYPE   = 1;
    localparam int CLS_BRANCH  = 2;
    localparam int CLS_CBRANCH = 3;
    localparam int CLS_ILLEGAL = 4;

    typedef enum logic [CLASS_W-1:0] {
        IC_NONE    = 5'b00000,
        IC_RTYPE   = 5'b00001 << CLS_RTYPE,
        IC_DTYPE   = 5'b00001 << CLS_DTYPE,
        IC_BRANCH  = 5'b00001 << CLS_BRANCH,
        IC_CBRANCH = 5'b00001 << CLS_CBRANCH,
        IC_ILLEGAL = 5'b00001 << CLS_ILLEGAL
    } instr_class_t;

    function automatic logic op_match(input logic [OPCODE_W-1:0] op,
                                      input logic [OPCODE_W-1:0] pat,
                                      input logic [OPCODE_W-1:0] mask);
        return (op & mask) == (pat & mask);
    endfunction

    // Patterns are disjoint, so the priority order only guarantees one-hot
    function automatic instr_class_t classify(input logic [OPCODE_W-1:0] op);
        if (op_match(op, OP_ADDS, MASK_FULL) || op_match(op, OP_SUBS, MASK_FULL) ||
            op_match(op, OP_AND,  MASK_FULL) || op_match(op, OP_EOR,  MASK_FULL))
            return IC_RTYPE;
        if (op_match(op, OP_LDUR, MASK_FULL) || op_match(op, OP_STUR, MASK_FULL))
            return IC_DTYPE;
        if (op_match(op, OP_B, MASK_B))
            return IC_BRANCH;
        if (op_match(op, OP_CBZ, MASK_CB) || op_match(op, OP_BCOND, MASK_CB))
            return IC_CBRANCH;
        return IC_ILLEGAL;
    endfunction

endpackage

// File: rtl/if_id_skid.sv
// Generic two-entry skid buffer: main register drives the output, skid
// register catches the one beat that arrives while the output is stalled.
module if_id_skid #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             main_valid_reg, main_valid_next;
    logic             skid_valid_reg, skid_valid_next;
    logic [WIDTH-1:0] main_data_reg,  main_data_next;
    logic [WIDTH-1:0] skid_data_reg,  skid_data_next;
    logic             accept;
    logic             drain;

    assign in_ready  = ~skid_valid_reg;
    assign out_valid = main_valid_reg;
    assign out_data  = main_data_reg;
    assign accept    = in_valid & in_ready;
    assign drain     = main_valid_reg & out_ready;

    always_comb begin
        main_valid_next = main_valid_reg;
        skid_valid_next = skid_valid_reg;
        main_data_next  = main_data_reg;
        skid_data_next  = skid_data_reg;
        if (flush) begin
            main_valid_next = 1'b0;
            skid_valid_next = 1'b0;
        end else if (skid_valid_reg) begin
            // in_ready is low here, so only the skid-to-main shift can happen
            if (drain) begin
                main_data_next  = skid_data_reg;
                skid_valid_next = 1'b0;
            end
        end else if (accept) begin
            if (!main_valid_reg || drain) begin
                main_data_next  = in_data;
                main_valid_next = 1'b1;
            end else begin
                skid_data_next  = in_data;
                skid_valid_next = 1'b1;
            end
        end else if (drain) begin
            main_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
            main_data_reg  <= '0;
            skid_data_reg  <= '0;
        end else begin
            main_valid_reg <= main_valid_next;
            skid_valid_reg <= skid_valid_next;
            main_data_reg  <= main_data_next;
            skid_data_reg  <= skid_data_next;
        end
    end

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register for the LEGv8 CPU: skid-buffered instruction and PC
// with the opcode field and a one-hot instruction class decoded on entry.
module if_id_stage
    import legv8_pkg::*;
#(
    parameter int PC_W    = 64,
    parameter int INSTR_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [INSTR_W-1:0]  in_instr,
    input  logic [PC_W-1:0]     in_pc,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [INSTR_W-1:0]  out_instr,
    output logic [PC_W-1:0]     out_pc,
    output logic [OPCODE_W-1:0] out_opcode,
    output logic [CLASS_W-1:0]  out_class
);

    localparam int DATA_W = CLASS_W + PC_W + INSTR_W;

    generate
        if (INSTR_W != 32) begin : g_bad_instr_w
            $error("if_id_stage: INSTR_W must be 32");
        end
    endgenerate

    instr_class_t      in_class;
    logic [DATA_W-1:0] in_data;
    logic [DATA_W-1:0] out_data;

    // Decoding before the register keeps the class off the decode-stage path
    assign in_class = classify(in_instr[OPCODE_MSB:OPCODE_LSB]);
    assign in_data  = {in_class, in_pc, in_instr};

    if_id_skid #(
        .WIDTH (DATA_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    assign {out_class, out_pc, out_instr} = out_data;
    assign out_opcode = out_instr[OPCODE_MSB:OPCODE_LSB];

endmodule
